// File: rtl/channel_selecter_seq.sv
// -----------------------------------------------------------------------------
// channel_selecter_seq
//
// Registered N-channel, W-bit selector with a valid flag. The outputs are
// registered, so a downstream display or output stage sees a glitch-free
// selection.
//
// There are two modes:
//   MANUAL  SW picks a channel. 0, or any value above N, selects nothing.
//   SCAN    Round-robin over channels 1..N, presenting each one for DWELL
//           cycles. SW is ignored in this mode.
//
// O always tracks the live DIN of the selected channel. It is not a
// snapshot taken when the channel was chosen.
//
// Parameters
//   N      number of input channels (>= 2)
//   W      data width per channel (>= 1)
//   SW_W   select / channel-index width (2**SW_W > N)
//   DWELL  cycles spent on each channel in SCAN mode (>= 1)
//
// Ports
//   CLK   in   1      clock, rising edge
//   RST   in   1      asynchronous, active-high reset
//   DIN   in   N*W    channel data; channel k (1..N) = DIN[(k-1)*W +: W]
//   SW    in   SW_W   manual select; 0 or >N = none, 1..N = channel
//   MODE  in   1      0 = MANUAL, 1 = SCAN
//   O     out  W      selected data (registered)
//   EN    out  1      1 when O carries a valid channel (registered)
//   CH    out  SW_W   channel index currently driving O; 0 = none
// -----------------------------------------------------------------------------
module channel_selecter_seq #(
    parameter int N     = 3,
    parameter int W     = 3,
    parameter int SW_W  = 2,
    parameter int DWELL = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N*W-1:0]    DIN,
    input  logic [SW_W-1:0]   SW,
    input  logic              MODE,
    output logic [W-1:0]      O,
    output logic              EN,
    output logic [SW_W-1:0]   CH
);

    localparam int CNT_W = $clog2(DWELL) + 1;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam logic [SW_W-1:0]  CH_FIRST = SW_W'(1);
    localparam logic [SW_W-1:0]  CH_LAST  = SW_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    // Unpack the flat data bus into one entry per channel (index 0 = channel 1).
    logic [W-1:0] chan_data [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = DIN[gi*W +: W];
        end
    endgenerate

    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [SW_W-1:0]  ch_reg,    ch_next;
    logic [W-1:0]     o_reg,     o_next;
    logic             en_reg,    en_next;

    always_comb begin
        state_next = MODE ? ST_SCAN : ST_MANUAL;
        cnt_next   = '0;
        ch_next    = '0;
        en_next    = 1'b0;

        if (!MODE) begin
            // MANUAL, which includes the edge leaving SCAN. SW takes effect
            // immediately, so the scanned channel gets no extra cycle.
            if ((SW != '0) && (SW <= CH_LAST)) begin
                ch_next = SW;
                en_next = 1'b1;
            end
        end else if (state_reg == ST_MANUAL) begin
            // Entering SCAN always starts from channel 1 with a fresh dwell.
            ch_next = CH_FIRST;
            en_next = 1'b1;
        end else begin
            en_next = 1'b1;
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                ch_next  = (ch_reg == CH_LAST) ? CH_FIRST : ch_reg + 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
                ch_next  = ch_reg;
            end
        end

        // Data follows the new channel index. When nothing is selected, O is 0.
        o_next = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_next == SW_W'(k + 1)) begin
                o_next = chan_data[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_MANUAL;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            o_reg     <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ch_reg    <= ch_next;
            o_reg     <= o_next;
            en_reg    <= en_next;
        end
    end

    assign O  = o_reg;
    assign EN = en_reg;
    assign CH = ch_reg;

endmodule

// File: tb/tb_channel_selecter_seq.sv
// -----------------------------------------------------------------------------
// tb_channel_selecter_seq
//
// Directed bench for channel_selecter_seq. It instantiates two copies of the
// design:
//   dut   N=3, W=3, DWELL=4 (the main configuration)
//   dut1  the same configuration with DWELL=1
//
// Both copies share the clock, reset, data and SW inputs. Each copy has its
// own MODE input.
//
// Channel data: ch1=3, ch2=2, ch3=5.
// -----------------------------------------------------------------------------
module tb_channel_selecter_seq;

    localparam int N    = 3;
    localparam int W    = 3;
    localparam int SW_W = 2;

    logic            CLK;
    logic            RST;
    logic [N*W-1:0]  DIN;
    logic [SW_W-1:0] SW;
    logic            MODE;
    logic [W-1:0]    O;
    logic            EN;
    logic [SW_W-1:0] CH;

    logic            mode1;
    logic [W-1:0]    o1;
    logic            en1;
    logic [SW_W-1:0] ch1;

    int checks   = 0;
    int failures = 0;

    channel_selecter_seq #(.N(N), .W(W), .SW_W(SW_W), .DWELL(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .DIN  (DIN),
        .SW   (SW),
        .MODE (MODE),
        .O    (O),
        .EN   (EN),
        .CH   (CH)
    );

    channel_selecter_seq #(.N(N), .W(W), .SW_W(SW_W), .DWELL(1)) dut1 (
        .CLK  (CLK),
        .RST  (RST),
        .DIN  (DIN),
        .SW   (SW),
        .MODE (mode1),
        .O    (o1),
        .EN   (en1),
        .CH   (ch1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Wait for the next rising edge, then step just past it so outputs are settled.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        // Reset is asserted from time 0. Check the outputs before any edge arrives.
        #2;
        checks++;
        if (O !== 3'd0 || EN !== 1'b0 || CH !== 2'd0) begin
            failures++;
            $display("FAIL reset_initial: O=%0d EN=%0b CH=%0d want 0/0/0", O, EN, CH);
        end
        $display("reset_initial: O=%0d EN=%0b CH=%0d", O, EN, CH);

        tick();
        #3 RST = 1'b0;

        // Load a non-zero selection, then assert reset between clock edges.
        SW = 2'd2;
        tick();
        checks++;
        if (O !== 3'd2 || EN !== 1'b1 || CH !== 2'd2) begin
            failures++;
            $display("FAIL pre_async: O=%0d EN=%0b CH=%0d want 2/1/2", O, EN, CH);
        end

        #3 RST = 1'b1;
        #1;
        checks++;
        if (O !== 3'd0 || EN !== 1'b0 || CH !== 2'd0) begin
            failures++;
            $display("FAIL reset_async: O=%0d EN=%0b CH=%0d want 0/0/0", O, EN, CH);
        end
        $display("reset_async: O=%0d EN=%0b CH=%0d", O, EN, CH);

        // Reset must hold the outputs low across a clock edge.
        tick();
        checks++;
        if (O !== 3'd0 || EN !== 1'b0 || CH !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold: O=%0d EN=%0b CH=%0d want 0/0/0", O, EN, CH);
        end

        #2 RST = 1'b0;
    endtask

    task automatic test_manual();
        logic [SW_W-1:0] sw_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [W-1:0]    o_exp  [4] = '{3'd3, 3'd2, 3'd5, 3'd0};
        logic            en_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

        MODE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SW = sw_seq[i];
            tick();
            checks++;
            if (O !== o_exp[i] || EN !== en_exp[i] || CH !== sw_seq[i]) begin
                failures++;
                $display("FAIL manual[%0d]: O=%0d EN=%0b CH=%0d want %0d/%0b/%0d",
                         i, O, EN, CH, o_exp[i], en_exp[i], sw_seq[i]);
            end
            $display("manual SW=%0d: O=%0d EN=%0b CH=%0d", sw_seq[i], O, EN, CH);
        end
    endtask

    task automatic test_manual_live_data();
        MODE = 1'b0;
        SW   = 2'd1;
        tick();

        // O must follow the live data of the selected channel.
        DIN[2:0] = 3'd7;
        tick();
        checks++;
        if (O !== 3'd7 || EN !== 1'b1 || CH !== 2'd1) begin
            failures++;
            $display("FAIL live_data: O=%0d EN=%0b CH=%0d want 7/1/1", O, EN, CH);
        end
        $display("live_data: O=%0d EN=%0b CH=%0d", O, EN, CH);

        SW = 2'd0;
        tick();
        checks++;
        if (O !== 3'd0 || EN !== 1'b0 || CH !== 2'd0) begin
            failures++;
            $display("FAIL sw_none: O=%0d EN=%0b CH=%0d want 0/0/0", O, EN, CH);
        end

        DIN[2:0] = 3'd3;
    endtask

    task automatic test_scan();
        logic [SW_W-1:0] ch_exp [14] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                         2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1};
        logic [W-1:0]    dat    [4]  = '{3'd0, 3'd3, 3'd2, 3'd5};

        MODE = 1'b1;
        // SW is ignored in SCAN mode. Drive a value that would select channel 3
        // in MANUAL mode.
        SW = 2'd3;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (CH !== ch_exp[i] || EN !== 1'b1 || O !== dat[ch_exp[i]]) begin
                failures++;
                $display("FAIL scan[%0d]: O=%0d EN=%0b CH=%0d want %0d/1/%0d",
                         i, O, EN, CH, dat[ch_exp[i]], ch_exp[i]);
            end
            $display("scan cycle %0d: O=%0d EN=%0b CH=%0d", i, O, EN, CH);
        end
    endtask

    task automatic test_scan_to_manual();
        // The scan is now at CH=1, cnt=1. Four more edges reach CH=2, cnt=1.
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (CH !== 2'd2 || O !== 3'd2) begin
            failures++;
            $display("FAIL scan_pos: O=%0d CH=%0d want 2/2", O, CH);
        end

        MODE = 1'b0;
        SW   = 2'd3;
        tick();
        checks++;
        if (O !== 3'd5 || EN !== 1'b1 || CH !== 2'd3) begin
            failures++;
            $display("FAIL scan_exit: O=%0d EN=%0b CH=%0d want 5/1/3", O, EN, CH);
        end
        $display("scan_exit: O=%0d EN=%0b CH=%0d", O, EN, CH);

        // Re-entering SCAN restarts at channel 1 for a full dwell.
        MODE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (CH !== ((i < 4) ? 2'd1 : 2'd2)) begin
                failures++;
                $display("FAIL scan_reentry[%0d]: CH=%0d want %0d",
                         i, CH, (i < 4) ? 1 : 2);
            end
            $display("scan_reentry %0d: O=%0d EN=%0b CH=%0d", i, O, EN, CH);
        end
    endtask

    task automatic test_reset_mid_scan();
        // The scan is now at CH=2, cnt=0. Four more edges reach CH=3.
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (CH !== 2'd3 || O !== 3'd5) begin
            failures++;
            $display("FAIL scan_ch3: O=%0d CH=%0d want 5/3", O, CH);
        end

        #3 RST = 1'b1;
        #1;
        checks++;
        if (O !== 3'd0 || EN !== 1'b0 || CH !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_scan: O=%0d EN=%0b CH=%0d want 0/0/0", O, EN, CH);
        end
        $display("reset_mid_scan: O=%0d EN=%0b CH=%0d", O, EN, CH);

        tick();
        #2 RST = 1'b0;

        // After reset, the scan restarts from channel 1 with a full dwell.
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (CH !== ((i < 4) ? 2'd1 : 2'd2) || EN !== 1'b1) begin
                failures++;
                $display("FAIL scan_after_reset[%0d]: EN=%0b CH=%0d want 1/%0d",
                         i, EN, CH, (i < 4) ? 1 : 2);
            end
            $display("scan_after_reset %0d: O=%0d EN=%0b CH=%0d", i, O, EN, CH);
        end
        MODE = 1'b0;
    endtask

    task automatic test_dwell1();
        logic [SW_W-1:0] ch_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [W-1:0]    o_exp  [4] = '{3'd3, 3'd2, 3'd5, 3'd3};

        mode1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ch1 !== ch_exp[i] || o1 !== o_exp[i] || en1 !== 1'b1) begin
                failures++;
                $display("FAIL dwell1[%0d]: O=%0d EN=%0b CH=%0d want %0d/1/%0d",
                         i, o1, en1, ch1, o_exp[i], ch_exp[i]);
            end
            $display("dwell1 cycle %0d: O=%0d EN=%0b CH=%0d", i, o1, en1, ch1);
        end
        mode1 = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        DIN   = {3'b101, 3'b010, 3'b011};
        SW    = 2'd0;
        MODE  = 1'b0;
        mode1 = 1'b0;

        test_reset();
        test_manual();
        test_manual_live_data();
        test_scan();
        test_scan_to_manual();
        test_reset_mid_scan();
        test_dwell1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
